// File: rtl/utils.sv
// Shared ghost-mode types, schedule table and small helpers used by the
// ghost mode scheduler and its phase timer.
package utils;

  localparam int NUM_GHOSTS       = 4;
  localparam int NUM_SCHED_PHASES = 7;

  typedef enum logic [1:0] {
    SCATTER = 2'd0,
    CHASE   = 2'd1,
    AFFRAID = 2'd2,
    EATEN   = 2'd3
  } ghost_modes_t;

  // Frames per timed phase; phase index 7 is the open-ended final CHASE.
  localparam logic [10:0] PHASE_DURATION [NUM_SCHED_PHASES] = '{
    11'd420, 11'd1200, 11'd420, 11'd1200, 11'd300, 11'd1200, 11'd300
  };

  function automatic logic [10:0] phase_duration(input logic [2:0] idx);
    logic [10:0] dur;
    dur = '0;
    for (int i = 0; i < NUM_SCHED_PHASES; i++) begin
      if (idx == 3'(i)) dur = PHASE_DURATION[i];
    end
    return dur;
  endfunction

  function automatic ghost_modes_t phase_mode(input logic [2:0] idx);
    return idx[0] ? CHASE : SCATTER;
  endfunction

  function automatic logic [2:0] count_ones(input logic [NUM_GHOSTS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ghost_phase_timer.sv
// Scatter/chase schedule walker: counts unfrozen frames in the current phase
// and strobes phase_change on the frame that ends it.
module ghost_phase_timer
  import utils::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         level_start,
  input  logic         frame_tick,
  input  logic         freeze,
  output logic         phase_change,
  output ghost_modes_t next_phase
);

  logic [2:0]  phase_idx_q, phase_idx_d;
  logic [10:0] phase_cnt_q, phase_cnt_d;
  logic        last_phase;
  logic        count_en;
  logic        at_end;

  // phase_change is a same-cycle strobe so the top can register the new
  // ghost modes on the very edge that retires the old phase.
  always_comb begin
    last_phase   = (phase_idx_q == 3'd7);
    count_en     = frame_tick & ~freeze & ~last_phase;
    at_end       = (phase_cnt_q == phase_duration(phase_idx_q) - 11'd1);
    phase_change = count_en & at_end & ~level_start;
    next_phase   = phase_mode(phase_idx_q + 3'd1);
    phase_idx_d  = phase_idx_q;
    phase_cnt_d  = phase_cnt_q;
    if (level_start) begin
      phase_idx_d = '0;
      phase_cnt_d = '0;
    end else if (count_en) begin
      if (at_end) begin
        phase_idx_d = phase_idx_q + 3'd1;
        phase_cnt_d = '0;
      end else begin
        phase_cnt_d = phase_cnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_idx_q <= '0;
      phase_cnt_q <= '0;
    end else begin
      phase_idx_q <= phase_idx_d;
      phase_cnt_q <= phase_cnt_d;
    end
  end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Central ghost mode controller: schedule phases, fright timer with twinkle,
// eat chain scoring and eaten-ghost return tracking for all four ghosts.
module ghost_mode_scheduler
  import utils::*;
#(
  parameter int FRIGHT_FRAMES  = 360,
  parameter int TWINKLE_FRAMES = 120,
  parameter int TWINKLE_PERIOD = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic                            pause,
  input  logic                            level_start,
  input  logic                            power_pellet,
  input  logic [NUM_GHOSTS-1:0]           ghost_eaten,
  input  logic [NUM_GHOSTS-1:0]           ghost_home,
  output ghost_modes_t [NUM_GHOSTS-1:0]   ghost_state,
  output ghost_modes_t                    global_phase,
  output logic                            twinkle,
  output logic [NUM_GHOSTS-1:0]           reverse,
  output logic                            eat_valid,
  output logic [1:0]                      eat_mult
);

  localparam int TW_W = $clog2(TWINKLE_PERIOD + 1);

  ghost_modes_t [NUM_GHOSTS-1:0] ghost_state_q, ghost_state_d;
  ghost_modes_t                  global_phase_q, global_phase_d;
  logic                          twinkle_q, twinkle_d;
  logic [NUM_GHOSTS-1:0]         reverse_q, reverse_d;
  logic                          eat_valid_q, eat_valid_d;
  logic [1:0]                    eat_mult_q, eat_mult_d;
  logic [9:0]                    fright_cnt_q, fright_cnt_d;
  logic [1:0]                    chain_q, chain_d;
  logic [TW_W-1:0]               tw_cnt_q, tw_cnt_d;

  logic                          fright_active;
  logic                          fright_step;
  logic                          fright_expire;
  logic [NUM_GHOSTS-1:0]         eat_acc;
  logic [1:0]                    chain_base;
  logic [2:0]                    chain_sum;
  logic                          phase_change;
  ghost_modes_t                  next_phase;

  ghost_phase_timer u_phase_timer (
    .clk          (clk),
    .reset        (reset),
    .level_start  (level_start),
    .frame_tick   (frame_tick),
    .freeze       (pause | fright_active),
    .phase_change (phase_change),
    .next_phase   (next_phase)
  );

  always_comb begin
    fright_active  = (fright_cnt_q != '0);
    fright_step    = fright_active & frame_tick & ~pause;
    fright_expire  = fright_step & (fright_cnt_q == 10'd1) & ~power_pellet;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      eat_acc[i] = ghost_eaten[i] & (ghost_state_q[i] == AFFRAID);
    end
    chain_base     = power_pellet ? 2'd0 : chain_q;
    chain_sum      = {1'b0, chain_base} + count_ones(eat_acc);

    ghost_state_d  = ghost_state_q;
    global_phase_d = global_phase_q;
    twinkle_d      = twinkle_q;
    reverse_d      = '0;
    eat_valid_d    = 1'b0;
    eat_mult_d     = eat_mult_q;
    fright_cnt_d   = fright_cnt_q;
    chain_d        = chain_q;
    tw_cnt_d       = tw_cnt_q;

    if (level_start) begin
      for (int i = 0; i < NUM_GHOSTS; i++) ghost_state_d[i] = SCATTER;
      global_phase_d = SCATTER;
      twinkle_d      = 1'b0;
      fright_cnt_d   = '0;
      chain_d        = '0;
      tw_cnt_d       = '0;
    end else begin
      if (phase_change) global_phase_d = next_phase;

      if (power_pellet) begin
        fright_cnt_d = 10'(FRIGHT_FRAMES);
        twinkle_d    = 1'b0;
        tw_cnt_d     = '0;
      end else if (fright_step) begin
        fright_cnt_d = fright_cnt_q - 10'd1;
        // Twinkle window: start high at the threshold, then flip every period.
        if (fright_cnt_d == '0) begin
          twinkle_d = 1'b0;
          tw_cnt_d  = '0;
        end else if (fright_cnt_d == 10'(TWINKLE_FRAMES)) begin
          twinkle_d = 1'b1;
          tw_cnt_d  = '0;
        end else if (fright_cnt_d < 10'(TWINKLE_FRAMES)) begin
          if (tw_cnt_q == TW_W'(TWINKLE_PERIOD - 1)) begin
            twinkle_d = ~twinkle_q;
            tw_cnt_d  = '0;
          end else begin
            tw_cnt_d  = tw_cnt_q + 1'b1;
          end
        end
      end

      chain_d = (chain_sum > 3'd3) ? 2'd3 : chain_sum[1:0];
      if (|eat_acc) begin
        eat_valid_d = 1'b1;
        eat_mult_d  = chain_base;
      end

      // Eating wins over expiry and pellet so a ghost caught on the last
      // fright frame still goes home as EATEN.
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        if (eat_acc[i]) begin
          ghost_state_d[i] = EATEN;
        end else if (ghost_home[i] && ghost_state_q[i] == EATEN) begin
          ghost_state_d[i] = global_phase_d;
        end else if (power_pellet && ghost_state_q[i] != EATEN) begin
          ghost_state_d[i] = AFFRAID;
          reverse_d[i]     = 1'b1;
        end else if (fright_expire && ghost_state_q[i] == AFFRAID) begin
          ghost_state_d[i] = global_phase_d;
        end else if (phase_change &&
                     (ghost_state_q[i] == SCATTER || ghost_state_q[i] == CHASE)) begin
          ghost_state_d[i] = next_phase;
          reverse_d[i]     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_GHOSTS; i++) ghost_state_q[i] <= SCATTER;
      global_phase_q <= SCATTER;
      twinkle_q      <= 1'b0;
      reverse_q      <= '0;
      eat_valid_q    <= 1'b0;
      eat_mult_q     <= '0;
      fright_cnt_q   <= '0;
      chain_q        <= '0;
      tw_cnt_q       <= '0;
    end else begin
      ghost_state_q  <= ghost_state_d;
      global_phase_q <= global_phase_d;
      twinkle_q      <= twinkle_d;
      reverse_q      <= reverse_d;
      eat_valid_q    <= eat_valid_d;
      eat_mult_q     <= eat_mult_d;
      fright_cnt_q   <= fright_cnt_d;
      chain_q        <= chain_d;
      tw_cnt_q       <= tw_cnt_d;
    end
  end

  assign ghost_state  = ghost_state_q;
  assign global_phase = global_phase_q;
  assign twinkle      = twinkle_q;
  assign reverse      = reverse_q;
  assign eat_valid    = eat_valid_q;
  assign eat_mult     = eat_mult_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler: schedule, fright/twinkle timing,
// eat chain, return home, simultaneous events, pause and async reset.
module tb_ghost_mode_scheduler;
  import utils::*;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       pause;
  logic       level_start;
  logic       power_pellet;
  logic [3:0] ghost_eaten;
  logic [3:0] ghost_home;
  logic [7:0] gs;
  logic [1:0] gp;
  logic       twinkle;
  logic [3:0] reverse;
  logic       eat_valid;
  logic [1:0] eat_mult;

  int n_checks = 0;
  int n_pass   = 0;

  ghost_mode_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .pause        (pause),
    .level_start  (level_start),
    .power_pellet (power_pellet),
    .ghost_eaten  (ghost_eaten),
    .ghost_home   (ghost_home),
    .ghost_state  (gs),
    .global_phase (gp),
    .twinkle      (twinkle),
    .reverse      (reverse),
    .eat_valid    (eat_valid),
    .eat_mult     (eat_mult)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] g4(input logic [1:0] m3, input logic [1:0] m2,
                                    input logic [1:0] m1, input logic [1:0] m0);
    return {m3, m2, m1, m0};
  endfunction

  function automatic logic [7:0] all4(input logic [1:0] m);
    return {m, m, m, m};
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are read at the same point, after the edge that sampled the stimulus.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic tick_now();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_level_start();
    level_start = 1'b1;
    step();
    level_start = 1'b0;
  endtask

  task automatic pulse_pellet();
    power_pellet = 1'b1;
    step();
    power_pellet = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (gs !== all4(SCATTER)) $display("FAIL reset_state: got %h want %h", gs, all4(SCATTER)); else n_pass++;
    n_checks++; if (gp !== SCATTER) $display("FAIL reset_phase: got %0d want %0d", gp, SCATTER); else n_pass++;
    n_checks++; if (twinkle !== 1'b0) $display("FAIL reset_twinkle: got %b want 0", twinkle); else n_pass++;
    n_checks++; if (reverse !== 4'h0) $display("FAIL reset_reverse: got %h want 0", reverse); else n_pass++;
    n_checks++; if (eat_valid !== 1'b0) $display("FAIL reset_eat_valid: got %b want 0", eat_valid); else n_pass++;
    n_checks++; if (eat_mult !== 2'd0) $display("FAIL reset_eat_mult: got %0d want 0", eat_mult); else n_pass++;
  endtask

  task automatic test_schedule();
    pulse_level_start();
    ticks(419);
    n_checks++; if (gp !== SCATTER) $display("FAIL sched_419: got %0d want %0d", gp, SCATTER); else n_pass++;
    tick_now();
    n_checks++; if (gp !== CHASE) $display("FAIL sched_420_phase: got %0d want %0d", gp, CHASE); else n_pass++;
    n_checks++; if (gs !== all4(CHASE)) $display("FAIL sched_420_state: got %h want %h", gs, all4(CHASE)); else n_pass++;
    n_checks++; if (reverse !== 4'hF) $display("FAIL sched_420_rev: got %h want f", reverse); else n_pass++;
    step();
    n_checks++; if (reverse !== 4'h0) $display("FAIL sched_rev_width: got %h want 0", reverse); else n_pass++;
    ticks(1199);
    n_checks++; if (gp !== CHASE) $display("FAIL sched_1619: got %0d want %0d", gp, CHASE); else n_pass++;
    tick_now();
    n_checks++; if (gp !== SCATTER) $display("FAIL sched_1620_phase: got %0d want %0d", gp, SCATTER); else n_pass++;
    n_checks++; if (reverse !== 4'hF) $display("FAIL sched_1620_rev: got %h want f", reverse); else n_pass++;
    step();
  endtask

  task automatic test_fright_twinkle();
    pulse_level_start();
    ticks(100);
    pulse_pellet();
    n_checks++; if (gs !== all4(AFFRAID)) $display("FAIL fright_entry: got %h want %h", gs, all4(AFFRAID)); else n_pass++;
    n_checks++; if (reverse !== 4'hF) $display("FAIL fright_entry_rev: got %h want f", reverse); else n_pass++;
    ticks(239);
    n_checks++; if (twinkle !== 1'b0) $display("FAIL twinkle_121: got %b want 0", twinkle); else n_pass++;
    ticks(1);
    n_checks++; if (twinkle !== 1'b1) $display("FAIL twinkle_120: got %b want 1", twinkle); else n_pass++;
    ticks(14);
    n_checks++; if (twinkle !== 1'b1) $display("FAIL twinkle_106: got %b want 1", twinkle); else n_pass++;
    ticks(1);
    n_checks++; if (twinkle !== 1'b0) $display("FAIL twinkle_105: got %b want 0", twinkle); else n_pass++;
    ticks(15);
    n_checks++; if (twinkle !== 1'b1) $display("FAIL twinkle_90: got %b want 1", twinkle); else n_pass++;
    ticks(89);
    n_checks++; if (gs !== all4(AFFRAID)) $display("FAIL fright_cnt1_state: got %h want %h", gs, all4(AFFRAID)); else n_pass++;
    n_checks++; if (twinkle !== 1'b0) $display("FAIL twinkle_1: got %b want 0", twinkle); else n_pass++;
    tick_now();
    n_checks++; if (gs !== all4(SCATTER)) $display("FAIL fright_expire_state: got %h want %h", gs, all4(SCATTER)); else n_pass++;
    n_checks++; if (reverse !== 4'h0) $display("FAIL fright_expire_rev: got %h want 0", reverse); else n_pass++;
    n_checks++; if (twinkle !== 1'b0) $display("FAIL fright_expire_twinkle: got %b want 0", twinkle); else n_pass++;
    step();
    ticks(319);
    n_checks++; if (gp !== SCATTER) $display("FAIL fright_sched_779: got %0d want %0d", gp, SCATTER); else n_pass++;
    tick_now();
    n_checks++; if (gp !== CHASE) $display("FAIL fright_sched_780: got %0d want %0d", gp, CHASE); else n_pass++;
    step();
  endtask

  task automatic test_eat_chain();
    pulse_level_start();
    pulse_pellet();
    ghost_eaten = 4'b0001; step(); ghost_eaten = 4'b0000;
    n_checks++; if (eat_valid !== 1'b1) $display("FAIL eat0_valid: got %b want 1", eat_valid); else n_pass++;
    n_checks++; if (eat_mult !== 2'd0) $display("FAIL eat0_mult: got %0d want 0", eat_mult); else n_pass++;
    n_checks++; if (gs !== g4(AFFRAID, AFFRAID, AFFRAID, EATEN)) $display("FAIL eat0_state: got %h want %h", gs, g4(AFFRAID, AFFRAID, AFFRAID, EATEN)); else n_pass++;
    step();
    n_checks++; if (eat_valid !== 1'b0) $display("FAIL eat_valid_width: got %b want 0", eat_valid); else n_pass++;
    ghost_eaten = 4'b0010; step(); ghost_eaten = 4'b0000;
    n_checks++; if (eat_mult !== 2'd1) $display("FAIL eat1_mult: got %0d want 1", eat_mult); else n_pass++;
    ghost_eaten = 4'b1100; step(); ghost_eaten = 4'b0000;
    n_checks++; if (eat_mult !== 2'd2) $display("FAIL eat23_mult: got %0d want 2", eat_mult); else n_pass++;
    n_checks++; if (gs !== all4(EATEN)) $display("FAIL eat23_state: got %h want %h", gs, all4(EATEN)); else n_pass++;
    ghost_eaten = 4'b0001; step(); ghost_eaten = 4'b0000;
    n_checks++; if (eat_valid !== 1'b0) $display("FAIL eat_ignored: got %b want 0", eat_valid); else n_pass++;
    ghost_home = 4'b0001; step(); ghost_home = 4'b0000;
    n_checks++; if (gs !== g4(EATEN, EATEN, EATEN, SCATTER)) $display("FAIL home0_state: got %h want %h", gs, g4(EATEN, EATEN, EATEN, SCATTER)); else n_pass++;
    ticks(310);
    pulse_pellet();
    n_checks++; if (gs !== g4(EATEN, EATEN, EATEN, AFFRAID)) $display("FAIL repellet_state: got %h want %h", gs, g4(EATEN, EATEN, EATEN, AFFRAID)); else n_pass++;
    n_checks++; if (reverse !== 4'b0001) $display("FAIL repellet_rev: got %h want 1", reverse); else n_pass++;
    ticks(239);
    n_checks++; if (twinkle !== 1'b0) $display("FAIL repellet_tw_121: got %b want 0", twinkle); else n_pass++;
    ticks(1);
    n_checks++; if (twinkle !== 1'b1) $display("FAIL repellet_tw_120: got %b want 1", twinkle); else n_pass++;
    ghost_eaten = 4'b0001; step(); ghost_eaten = 4'b0000;
    n_checks++; if (eat_mult !== 2'd0) $display("FAIL repellet_chain: got %0d want 0", eat_mult); else n_pass++;
    n_checks++; if (eat_valid !== 1'b1) $display("FAIL repellet_eat_valid: got %b want 1", eat_valid); else n_pass++;
    step();
  endtask

  task automatic test_expiry_eat();
    pulse_level_start();
    pulse_pellet();
    ticks(359);
    frame_tick  = 1'b1;
    ghost_eaten = 4'b0100;
    step();
    frame_tick  = 1'b0;
    ghost_eaten = 4'b0000;
    n_checks++; if (gs !== g4(SCATTER, EATEN, SCATTER, SCATTER)) $display("FAIL expiry_eat_state: got %h want %h", gs, g4(SCATTER, EATEN, SCATTER, SCATTER)); else n_pass++;
    n_checks++; if (eat_valid !== 1'b1) $display("FAIL expiry_eat_valid: got %b want 1", eat_valid); else n_pass++;
    n_checks++; if (reverse !== 4'h0) $display("FAIL expiry_eat_rev: got %h want 0", reverse); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    pulse_level_start();
    ticks(419);
    frame_tick   = 1'b1;
    power_pellet = 1'b1;
    step();
    frame_tick   = 1'b0;
    power_pellet = 1'b0;
    n_checks++; if (gp !== CHASE) $display("FAIL b2b_phase: got %0d want %0d", gp, CHASE); else n_pass++;
    n_checks++; if (gs !== all4(AFFRAID)) $display("FAIL b2b_state: got %h want %h", gs, all4(AFFRAID)); else n_pass++;
    n_checks++; if (reverse !== 4'hF) $display("FAIL b2b_rev: got %h want f", reverse); else n_pass++;
    step();
    n_checks++; if (reverse !== 4'h0) $display("FAIL b2b_single_rev: got %h want 0", reverse); else n_pass++;
    ticks(360);
    n_checks++; if (gs !== all4(CHASE)) $display("FAIL b2b_expire_state: got %h want %h", gs, all4(CHASE)); else n_pass++;
    pulse_pellet();
    pulse_level_start();
    n_checks++; if (gs !== all4(SCATTER)) $display("FAIL lvl_state: got %h want %h", gs, all4(SCATTER)); else n_pass++;
    n_checks++; if (gp !== SCATTER) $display("FAIL lvl_phase: got %0d want %0d", gp, SCATTER); else n_pass++;
    step();
  endtask

  task automatic test_pause_reset();
    pulse_level_start();
    ticks(200);
    pause = 1'b1;
    ticks(500);
    pause = 1'b0;
    n_checks++; if (gp !== SCATTER) $display("FAIL pause_phase: got %0d want %0d", gp, SCATTER); else n_pass++;
    ticks(219);
    n_checks++; if (gp !== SCATTER) $display("FAIL pause_419: got %0d want %0d", gp, SCATTER); else n_pass++;
    tick_now();
    n_checks++; if (gp !== CHASE) $display("FAIL pause_420: got %0d want %0d", gp, CHASE); else n_pass++;
    step();
    pulse_pellet();
    pause = 1'b1;
    ticks(300);
    pause = 1'b0;
    n_checks++; if (gs !== all4(AFFRAID)) $display("FAIL pause_fright: got %h want %h", gs, all4(AFFRAID)); else n_pass++;
    ticks(250);
    n_checks++; if (twinkle !== 1'b1) $display("FAIL pause_tw_110: got %b want 1", twinkle); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (gs !== all4(SCATTER)) $display("FAIL async_rst_state: got %h want %h", gs, all4(SCATTER)); else n_pass++;
    n_checks++; if (gp !== SCATTER) $display("FAIL async_rst_phase: got %0d want %0d", gp, SCATTER); else n_pass++;
    n_checks++; if (twinkle !== 1'b0) $display("FAIL async_rst_twinkle: got %b want 0", twinkle); else n_pass++;
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    reset        = 1'b0;
    frame_tick   = 1'b0;
    pause        = 1'b0;
    level_start  = 1'b0;
    power_pellet = 1'b0;
    ghost_eaten  = 4'b0000;
    ghost_home   = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    step();
    test_schedule();
    test_fright_twinkle();
    test_eat_chain();
    test_expiry_eat();
    test_back_to_back();
    test_pause_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
